axi_addr_arbiter: RTL and testbench

Per-slave round-robin arbiter for the crossbar address channels (AR or AW). Takes one slave's decoded valid bit from each master interface's async-FIFO read side, grants one master, pops that master's FIFO, and presents the captured 49-bit address packet to the slave with a registered VALID/READY handshake. One instance sits in front of each slave port per address channel. An optional lock holds the grant until the burst completes, so W data can be steered by `GRANT_o`.

---
 rtl/axi_addr_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_axi_addr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_addr_arbiter.sv
// axi_addr_arbiter: per-slave round-robin arbiter for the crossbar AR/AW
// address channels. Picks one master's FIFO head, pops that FIFO, and holds
// the captured packet on a registered VALID/READY handshake toward the slave.
//
// Build option: define ARB_LOCK_EN to keep the grant after the address
// handshake until DONE_i (burst complete), so W data / responses can be
// steered by GRANT_o. Without it the grant drops right after the handshake.

// Per-master lane: priority rank relative to the last winner, and the FIFO
// head gated by this lane's win bit so the top can OR-reduce the winner.
module axi_addr_arb_lane #(
  parameter int M_CNT  = 3,
  parameter int DATA_W = 49,
  parameter int IDX    = 0,
  parameter int LW     = 2
) (
  input  logic [LW-1:0]     last,
  input  logic              win,
  input  logic [DATA_W-1:0] data,
  output logic [LW-1:0]     rank,
  output logic [DATA_W-1:0] data_gated
);

  int r;

  // rank 0 = next in line after the last winner, wrapping modulo M_CNT
  always_comb begin
    r = IDX - int'(last) - 1;
    if (r < 0) r = r + M_CNT;
    rank = LW'(r);
  end

  assign data_gated = data & {DATA_W{win}};

endmodule

module axi_addr_arbiter #(
  parameter int M_CNT  = 3,
  parameter int DATA_W = 49
) (
  input  logic                    AXI_CLK_i,
  input  logic                    AXI_RST_i,
  input  logic [M_CNT-1:0]        REQ_i,
  input  logic [M_CNT*DATA_W-1:0] REQ_DATA_i,
  output logic [M_CNT-1:0]        POP_o,
  output logic                    ADDR_VALID_o,
  output logic [DATA_W-1:0]       ADDR_DATA_o,
  input  logic                    ADDR_READY_i,
  input  logic                    DONE_i,
  output logic [M_CNT-1:0]        GRANT_o,
  output logic                    BUSY_o
);

  localparam int LW = $clog2(M_CNT);

`ifdef ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, LOCK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1} state_t;
  // DONE_i only matters when the lock is compiled in
  logic unused_done;
  assign unused_done = DONE_i;
`endif

  state_t state_q, state_d;

  logic [LW-1:0]                   last_q;
  logic [DATA_W-1:0]               data_q;
  logic [M_CNT-1:0]                grant_q;
  logic [M_CNT-1:0][LW-1:0]        rank;
  logic [M_CNT-1:0][DATA_W-1:0]    gated;
  logic [M_CNT-1:0]                win;
  logic [LW-1:0]                   win_idx;
  logic [DATA_W-1:0]               win_data;
  logic                            found;
  logic [M_CNT-1:0]                pop;
  logic                            load;
  logic                            clr_grant;

  generate
    for (genvar m = 0; m < M_CNT; m++) begin : g_lane
      axi_addr_arb_lane #(
        .M_CNT (M_CNT),
        .DATA_W(DATA_W),
        .IDX   (m),
        .LW    (LW)
      ) u_lane (
        .last      (last_q),
        .win       (win[m]),
        .data      (REQ_DATA_i[m*DATA_W +: DATA_W]),
        .rank      (rank[m]),
        .data_gated(gated[m])
      );
    end
  endgenerate

  // winner = requesting lane with the lowest rank (ranks are unique)
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int r = 0; r < M_CNT; r++) begin
      for (int m = 0; m < M_CNT; m++) begin
        if (!found && REQ_i[m] && rank[m] == LW'(r)) begin
          win[m]  = 1'b1;
          win_idx = LW'(m);
          found   = 1'b1;
        end
      end
    end
  end

  // at most one lane is gated through, so an OR acts as the mux
  always_comb begin
    win_data = '0;
    for (int m = 0; m < M_CNT; m++) win_data = win_data | gated[m];
  end

  // FSM state register
  always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
    if (!AXI_RST_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // next state, pop strobe and datapath controls
  always_comb begin
    state_d   = state_q;
    pop       = '0;
    load      = 1'b0;
    clr_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (|REQ_i) begin
          pop     = win;
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ADDR_READY_i) begin
`ifdef ARB_LOCK_EN
          // burst may already be done on the handshake cycle
          if (DONE_i) begin
            state_d   = IDLE;
            clr_grant = 1'b1;
          end else begin
            state_d = LOCK;
          end
`else
          state_d   = IDLE;
          clr_grant = 1'b1;
`endif
        end
      end
`ifdef ARB_LOCK_EN
      LOCK: begin
        if (DONE_i) begin
          state_d   = IDLE;
          clr_grant = 1'b1;
        end
      end
`endif
      default: begin
        state_d   = IDLE;
        clr_grant = 1'b1;
      end
    endcase
  end

  // captured packet, owner and round-robin pointer
  always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
    if (!AXI_RST_i) begin
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= LW'(M_CNT - 1);
    end else if (load) begin
      data_q  <= win_data;
      grant_q <= win;
      last_q  <= win_idx;
    end else if (clr_grant) begin
      grant_q <= '0;
    end
  end

  // never pop a FIFO while reset is held
  assign POP_o        = pop & {M_CNT{AXI_RST_i}};
  assign ADDR_VALID_o = (state_q == ISSUE);
  assign ADDR_DATA_o  = data_q;
  assign GRANT_o      = grant_q;
  assign BUSY_o       = (state_q != IDLE);

endmodule

// File: tb/tb_axi_addr_arbiter.sv
// Randomized + directed bench for axi_addr_arbiter (M_CNT=3, DATA_W=49).
// The reference model tracks the arbiter as phase/last-winner/packet and
// picks winners by modulo search over the request vector.
module tb_axi_addr_arbiter;
  localparam int M = 3;
  localparam int W = 49;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [M-1:0]      req;
  logic [M-1:0][W-1:0] req_data;
  logic              ready, done;
  logic [M-1:0]      pop, grant;
  logic              valid, busy;
  logic [W-1:0]      data;

  axi_addr_arbiter #(.M_CNT(M), .DATA_W(W)) dut (
    .AXI_CLK_i   (clk),
    .AXI_RST_i   (rst_n),
    .REQ_i       (req),
    .REQ_DATA_i  (req_data),
    .POP_o       (pop),
    .ADDR_VALID_o(valid),
    .ADDR_DATA_o (data),
    .ADDR_READY_i(ready),
    .DONE_i      (done),
    .GRANT_o     (grant),
    .BUSY_o      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;
  int pops    = 0;

  // model: ph 0=idle 1=issue 2=lock
  int           ph, mlast, mgnt;
  logic [W-1:0] mdata;

  // last observed outputs (for directed checks)
  logic [M-1:0] o_pop, o_grant;
  logic         o_valid, o_busy;
  logic [W-1:0] o_data;

  function automatic int pick(input logic [M-1:0] r, input int last);
    for (int k = 1; k <= M; k++) begin
      int idx;
      idx = (last + k) % M;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    return {8'($urandom), 32'($urandom), 4'($urandom), 3'($urandom), 2'($urandom)};
  endfunction

  task automatic rand_data(output logic [M-1:0][W-1:0] d);
    for (int m = 0; m < M; m++) d[m] = rand_pkt();
  endtask

  task automatic model_reset();
    ph = 0; mlast = M - 1; mgnt = 0; mdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // one clock: drive, check at negedge against the model, advance model
  task automatic step(input string nm, input logic [M-1:0] r,
                      input logic [M-1:0][W-1:0] d, input logic rdy, input logic dn);
    logic [M-1:0] e_pop, e_gnt;
    int w;
    req = r; req_data = d; ready = rdy; done = dn;
    @(negedge clk);
    w = pick(r, mlast);
    e_pop = '0;
    if (ph == 0 && w >= 0) e_pop[w] = 1'b1;
    e_gnt = '0;
    if (ph != 0) e_gnt[mgnt] = 1'b1;
    o_pop = pop; o_grant = grant; o_valid = valid; o_busy = busy; o_data = data;
    if (pop != '0) pops++;
    vectors++;
    if (pop !== e_pop || valid !== (ph == 1) || busy !== (ph != 0) ||
        grant !== e_gnt || data !== mdata) begin
      errs++;
      $display("FAIL %s: pop=%b want %b valid=%b want %b busy=%b want %b grant=%b want %b data=%h want %h",
               nm, pop, e_pop, valid, (ph == 1), busy, (ph != 0), grant, e_gnt, data, mdata);
    end
    @(posedge clk);
    case (ph)
      0: if (w >= 0) begin mdata = d[w]; mgnt = w; mlast = w; ph = 1; end
      1: if (rdy) ph = (LOCK_EN && !dn) ? 2 : 0;
      2: if (dn) ph = 0;
      default: ph = 0;
    endcase
    #1;
  endtask

  task automatic test_reset();
    req = 3'b111; ready = 1'b1; done = 1'b1; rand_data(req_data);
    rst_n = 1'b0;
    #2;
    vectors++;
    if (pop !== 3'b000 || valid !== 1'b0 || grant !== 3'b000 || busy !== 1'b0 || data !== '0) begin
      errs++;
      $display("FAIL reset: pop=%b valid=%b grant=%b busy=%b data=%h, want all zero",
               pop, valid, grant, busy, data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_grant();
    logic [M-1:0][W-1:0] d;
    rand_data(d);
    step("first_pop", 3'b111, d, 1'b0, 1'b0);
    vectors++;
    if (o_pop !== 3'b001) begin
      errs++; $display("FAIL first_pop: got %b want 001", o_pop);
    end
    step("first_valid", 3'b111, d, 1'b1, 1'b1);
    vectors++;
    if (o_grant !== 3'b001 || o_valid !== 1'b1 || o_data !== d[0]) begin
      errs++;
      $display("FAIL first_valid: grant=%b valid=%b data=%h want 001 1 %h", o_grant, o_valid, o_data, d[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [M-1:0][W-1:0] d;
    logic [M-1:0] exp_g[4];
    logic [M-1:0] gseq[$];
    int p0;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      rand_data(d);
      step("rr", 3'b111, d, 1'b1, 1'b1);
      if (o_valid) gseq.push_back(o_grant);
    end
    vectors++;
    if (gseq.size() != 4 || (pops - p0) != 4) begin
      errs++; $display("FAIL rr_count: grants=%0d pops=%0d want 4 4", gseq.size(), pops - p0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (gseq[i] !== exp_g[i]) begin
          errs++; $display("FAIL rr_order[%0d]: got %b want %b", i, gseq[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [M-1:0][W-1:0] d;
    logic [W-1:0] pkt;
    int p0, stable;
    pkt = {8'h13, 32'h1000_0000, 4'd3, 3'd2, 2'd1};
    rand_data(d);
    d[1] = pkt;
    p0 = pops;
    step("stall_pop", 3'b010, d, 1'b0, 1'b0);
    vectors++;
    if (o_pop !== 3'b010) begin
      errs++; $display("FAIL stall_pop: got %b want 010", o_pop);
    end
    stable = 0;
    for (int i = 0; i < 6; i++) begin
      rand_data(d);
      d[1] = pkt;
      step("stall_hold", 3'b011, d, (i == 5), 1'b0);
      if (o_valid === 1'b1 && o_data === pkt && o_grant === 3'b010) stable++;
    end
    vectors++;
    if (stable != 6 || (pops - p0) != 1) begin
      errs++; $display("FAIL stall_hold: stable=%0d pops=%0d want 6 1", stable, pops - p0);
    end
    step("stall_drop", 3'b000, d, 1'b0, 1'b1);
    vectors++;
    if (o_valid !== 1'b0) begin
      errs++; $display("FAIL stall_drop: valid=%b want 0", o_valid);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [M-1:0][W-1:0] d;
    rand_data(d);
    do_reset();
    step("lock_pop", 3'b001, d, 1'b0, 1'b0);
    step("lock_hs", 3'b010, d, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("lock_hold", 3'b010, d, 1'b1, 1'b0);
      vectors++;
      if (o_pop !== 3'b000 || o_grant !== 3'b001 || o_valid !== 1'b0) begin
        errs++; $display("FAIL lock_hold: pop=%b grant=%b valid=%b want 000 001 0", o_pop, o_grant, o_valid);
      end
    end
    step("lock_done", 3'b010, d, 1'b0, 1'b1);
    step("lock_next", 3'b010, d, 1'b0, 1'b0);
    vectors++;
    if (o_pop !== 3'b010 || o_grant !== 3'b000) begin
      errs++; $display("FAIL lock_next: pop=%b grant=%b want 010 000", o_pop, o_grant);
    end
    step("lock_hs_done", 3'b000, d, 1'b1, 1'b1);
    step("lock_idle", 3'b000, d, 1'b0, 1'b0);
    vectors++;
    if (o_busy !== 1'b0 || o_grant !== 3'b000) begin
      errs++; $display("FAIL lock_idle: busy=%b grant=%b want 0 000", o_busy, o_grant);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [M-1:0][W-1:0] d;
    rand_data(d);
    step("mid_pop", 3'b110, d, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (valid !== 1'b0 || grant !== 3'b000 || busy !== 1'b0 || pop !== 3'b000) begin
      errs++;
      $display("FAIL mid_reset: valid=%b grant=%b busy=%b pop=%b want 0 000 0 000", valid, grant, busy, pop);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step("post_reset", 3'b111, d, 1'b0, 1'b0);
    vectors++;
    if (o_pop !== 3'b001) begin
      errs++; $display("FAIL post_reset: pop=%b want 001", o_pop);
    end
    step("post_issue", 3'b111, d, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [M-1:0][W-1:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_data(d);
      step("random", M'($urandom_range(0, 7)), d,
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3));
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; ready = 1'b0; done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_stall();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
